bpsk_bit_sequencer: RTL and testbench

BPSK_BIT_SEQUENCER -- requirements
Module: bpsk_bit_sequencer

---
 rtl/core_params.sv | 14 +
 rtl/carrier_index_counter.sv | 25 ++
 rtl/bpsk_bit_sequencer.sv | 129 ++++++++++++
 tb/tb_bpsk_bit_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/core_params.sv
// Shared carrier/bit-timing defaults and the bit sequencer state type.
package core_params;

  localparam int   WAVELENGTH       = 10;   // clocks per carrier period
  localparam int   CARRIERS_PER_BIT = 2;    // carrier periods per transmitted bit
  localparam int   SINE_RESOLUTION  = 8;    // phase table sample width
  localparam logic IDLE_LEVEL       = 1'b1; // data level while no byte is in flight

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } seq_state_t;

endpackage

// File: rtl/carrier_index_counter.sv
// Free-running carrier sample index; flags the last sample of each period.
module carrier_index_counter #(
  parameter int WAVELENGTH = core_params::WAVELENGTH
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [$clog2(WAVELENGTH):0]   index,
  output logic                          boundary
);

  localparam int IW = $clog2(WAVELENGTH) + 1;
  localparam logic [IW-1:0] LAST = IW'(WAVELENGTH - 1);

  always_ff @(posedge clk) begin
    if (reset)
      index <= '0;
    else if (index == LAST)
      index <= '0;
    else
      index <= index + 1'b1;
  end

  assign boundary = (index == LAST);

endmodule

// File: rtl/bpsk_bit_sequencer.sv
// Serialises bytes MSB first onto the phase table data line, one bit per
// CARRIERS_PER_BIT carrier periods, switching only at carrier boundaries.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no byte in flight; data = IDLE_LEVEL, waiting for hold_full
// ST_SEND | shifting a byte out; per_cnt counts periods, bit_cnt counts bits
module bpsk_bit_sequencer
  import core_params::seq_state_t;
  import core_params::ST_IDLE;
  import core_params::ST_SEND;
#(
  parameter int   WAVELENGTH       = core_params::WAVELENGTH,
  parameter int   CARRIERS_PER_BIT = core_params::CARRIERS_PER_BIT,
  parameter logic IDLE_LEVEL       = core_params::IDLE_LEVEL
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    in_byte,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          data,
  output logic [$clog2(WAVELENGTH):0]   index,
  output logic                          busy,
  output logic                          bit_strobe
);

  localparam int PW = (CARRIERS_PER_BIT > 1) ? $clog2(CARRIERS_PER_BIT) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'(CARRIERS_PER_BIT - 1);

  seq_state_t    state, state_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    hold, hold_n;
  logic          hold_full, hold_full_n;
  logic [PW-1:0] per_cnt, per_cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic          data_n, strobe_n, load;
  logic          boundary;

  carrier_index_counter #(
    .WAVELENGTH (WAVELENGTH)
  ) u_index (
    .clk      (clk),
    .reset    (reset),
    .index    (index),
    .boundary (boundary)
  );

  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    hold_n      = hold;
    hold_full_n = hold_full;
    per_cnt_n   = per_cnt;
    bit_cnt_n   = bit_cnt;
    data_n      = data;
    strobe_n    = 1'b0;
    load        = 1'b0;

    // in_ready is low whenever hold_full is set, so accept and drain never coincide
    if (in_valid && in_ready) begin
      hold_n      = in_byte;
      hold_full_n = 1'b1;
    end

    if (boundary) begin
      case (state)
        ST_IDLE: begin
          if (hold_full)
            load = 1'b1;
        end
        ST_SEND: begin
          if (per_cnt != PER_LAST) begin
            per_cnt_n = per_cnt + 1'b1;
          end else if (bit_cnt != 3'd7) begin
            shreg_n   = {shreg[6:0], 1'b0};
            data_n    = shreg[6];
            bit_cnt_n = bit_cnt + 3'd1;
            per_cnt_n = '0;
            strobe_n  = 1'b1;
          end else if (hold_full) begin
            load = 1'b1;
          end else begin
            data_n  = IDLE_LEVEL;
            state_n = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end

    if (load) begin
      shreg_n     = hold;
      data_n      = hold[7];
      per_cnt_n   = '0;
      bit_cnt_n   = '0;
      strobe_n    = 1'b1;
      hold_full_n = 1'b0;
      state_n     = ST_SEND;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      per_cnt    <= '0;
      bit_cnt    <= '0;
      data       <= IDLE_LEVEL;
      bit_strobe <= 1'b0;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      hold       <= hold_n;
      hold_full  <= hold_full_n;
      per_cnt    <= per_cnt_n;
      bit_cnt    <= bit_cnt_n;
      data       <= data_n;
      bit_strobe <= strobe_n;
      in_ready   <= !hold_full_n;
      busy       <= (state_n == ST_SEND) || hold_full_n;
    end
  end

endmodule

// File: tb/tb_bpsk_bit_sequencer.sv
// Scoreboard bench for bpsk_bit_sequencer (WAVELENGTH=10, CARRIERS_PER_BIT=2).
module tb_bpsk_bit_sequencer;

  localparam int WL  = 10;
  localparam int CPB = 2;
  localparam int BITLEN = WL * CPB;
  localparam int IW  = $clog2(WL) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    in_byte = 8'h00, in_byte0 = 8'h00;
  logic          in_valid = 1'b0, in_valid0 = 1'b0;
  logic          in_ready, data, busy, bit_strobe;
  logic          in_ready0, data0, busy0, bit_strobe0;
  logic [IW-1:0] index, index0;

  always #5 clk = ~clk;

  bpsk_bit_sequencer #(.WAVELENGTH(WL), .CARRIERS_PER_BIT(CPB), .IDLE_LEVEL(1'b1)) dut (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .index(index), .busy(busy), .bit_strobe(bit_strobe));

  bpsk_bit_sequencer #(.WAVELENGTH(WL), .CARRIERS_PER_BIT(CPB), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_byte(in_byte0), .in_valid(in_valid0), .in_ready(in_ready0),
    .data(data0), .index(index0), .busy(busy0), .bit_strobe(bit_strobe0));

  typedef struct packed {
    logic b;       // expected bit value
    logic gapchk;  // previous strobe must be exactly one bit period earlier
    logic first;   // MSB of a byte: the preceding cycle was the drain cycle
  } exp_t;

  exp_t sb[$];
  logic sb0[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference index model
  int idx_model = 0;
  always @(posedge clk) begin
    if (reset) idx_model <= 0;
    else       idx_model <= (idx_model == WL - 1) ? 0 : idx_model + 1;
  end

  // output monitor for the IDLE_LEVEL=1 instance
  logic have_bit = 1'b0;
  logic last_bit = 1'b0;
  logic prev_rdy = 1'b1;
  int   gap = 0;
  int   n_strobe = 0;
  exp_t e;

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      have_bit = 1'b0;
      gap      = 0;
      prev_rdy = 1'b1;
    end else begin
      check_eq("index", int'(index), idx_model);
      gap = gap + 1;
      if (bit_strobe) begin
        n_strobe++;
        check_eq("strobe_index", int'(index), 0);
        if (sb.size() == 0) begin
          check_eq("spurious_strobe", int'(bit_strobe), 0);
        end else begin
          e = sb.pop_front();
          check_eq("bit", int'(data), int'(e.b));
          if (e.gapchk) check_eq("bit_period", gap, BITLEN);
          if (e.first)  check_eq("drain_ready", int'(prev_rdy), 0);
          have_bit = 1'b1;
          last_bit = e.b;
        end
        gap = 0;
      end else if (have_bit && gap < BITLEN) begin
        check_eq("data_hold", int'(data), int'(last_bit));
      end else begin
        check_eq("idle_data", int'(data), 1);
        if (sb.size() == 0) check_eq("idle_ready", int'(in_ready), 1);
      end
      check_eq("busy", int'(busy), int'((sb.size() > 0) || (have_bit && gap < BITLEN)));
      prev_rdy = in_ready;
    end
  end

  task automatic send_byte(input logic [7:0] v, input logic contig);
    int n = 0;
    in_byte  = v;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check_eq("accept_timeout", int'(in_ready), 1);
      return;
    end
    @(posedge clk);
    #1;
    for (int i = 7; i >= 0; i--)
      sb.push_back('{b: v[i], gapchk: (i != 7) || contig, first: (i == 7)});
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("drained", sb.size(), 0);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, s0, n0;

    // idle after reset
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("reset_ready", int'(in_ready), 1);
    check_eq("reset_data", int'(data), 1);
    check_eq("reset_strobe", int'(bit_strobe), 0);
    repeat (50) @(negedge clk);
    check_eq("idle_strobes", n_strobe, 0);

    // 8'hA5 offered at index 3
    n = 0;
    while (index != 3 && n < 20) begin @(negedge clk); n++; end
    send_byte(8'hA5, 1'b0);
    in_valid = 1'b0;
    // accepted on the edge ending index 3; first bit lands 6 edges later, seen on the 7th negedge
    lat = 0;
    while (!bit_strobe && lat < 20) begin @(negedge clk); lat++; end
    check_eq("first_bit_latency", lat, 7);
    wait_drain();
    check_eq("a5_strobes", n_strobe, 8);

    // back-to-back with valid held high
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b1);
    in_valid = 1'b0;
    wait_drain();

    // three bytes queued behind a 1-deep hold
    @(negedge clk);
    send_byte(8'h5A, 1'b0);
    send_byte(8'hC3, 1'b1);
    send_byte(8'h96, 1'b1);
    in_valid = 1'b0;
    wait_drain();
    check_eq("total_strobes", n_strobe, 8 * 6);

    // reset during bit 4 of 8'h3C with 8'h81 held
    @(negedge clk);
    s0 = n_strobe;
    send_byte(8'h3C, 1'b0);
    send_byte(8'h81, 1'b1);
    in_valid = 1'b0;
    n = 0;
    while (n_strobe < s0 + 4 && n < 200) begin @(negedge clk); n++; end
    check_eq("reached_bit4", n_strobe, s0 + 4);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_index", int'(index), 0);
    check_eq("rst_data", int'(data), 1);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_ready", int'(in_ready), 1);
    s0 = n_strobe;
    repeat (200) @(negedge clk);
    check_eq("rst_no_strobes", n_strobe, s0);

    // IDLE_LEVEL=0 instance with 8'h80
    n = 0;
    in_byte0  = 8'h80;
    in_valid0 = 1'b1;
    while (!in_ready0 && n < 50) begin @(negedge clk); n++; end
    check_eq("dut0_ready", int'(in_ready0), 1);
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    for (int i = 7; i >= 0; i--) sb0.push_back(in_byte0[i]);
    n0 = 0;
    for (int k = 0; k < 250; k++) begin
      @(negedge clk);
      if (bit_strobe0) begin
        n0++;
        if (sb0.size() == 0) check_eq("dut0_spurious_strobe", int'(bit_strobe0), 0);
        else                 check_eq("dut0_bit", int'(data0), int'(sb0.pop_front()));
      end else if (k > 200) begin
        check_eq("dut0_idle_data", int'(data0), 0);
      end
    end
    check_eq("dut0_strobes", n0, 8);
    check_eq("dut0_busy", int'(busy0), 0);
    check_eq("dut0_data_end", int'(data0), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
